// File: rtl/forwarding_unit_if.sv
// Decode-side bundle for forwarding_unit: ID fields and pipeline controls in, operand selects and load-use stall out.
// The statistics counter ports exist only when FWD_STATS_EN is defined.
interface forwarding_unit_if #(
    parameter int REG_ADDR_W = 5
`ifdef FWD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic                  freeze;
    logic [1:0]            fwd_sel_a;
    logic [1:0]            fwd_sel_b;
    logic                  stall;
`ifdef FWD_STATS_EN
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      fwd_count;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, flush, freeze,
        input  fwd_sel_a, fwd_sel_b, stall
`ifdef FWD_STATS_EN
        ,
        input  stall_count, fwd_count
`endif
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, flush, freeze,
        output fwd_sel_a, fwd_sel_b, stall
`ifdef FWD_STATS_EN
        ,
        output stall_count, fwd_count
`endif
    );
endinterface

// File: rtl/forwarding_unit.sv
// Forwarding and load-use hazard control for the 5-stage pipeline: tracks EX/MEM destinations, registers operand
// selects one cycle ahead and raises a combinational stall. Macro FWD_STATS_EN adds stall/forward counters.
module forwarding_unit #(
    parameter int REG_ADDR_W = 5
`ifdef FWD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    forwarding_unit_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
    localparam stage_t BUBBLE = '{valid: 1'b0, rd: REG_ZERO, reg_write: 1'b0, mem_read: 1'b0};

    stage_t     ex_q, ex_d;
    stage_t     mem_q, mem_d;
    logic [1:0] fwd_sel_a_q, fwd_sel_a_d;
    logic [1:0] fwd_sel_b_q, fwd_sel_b_d;
    logic [1:0] sel_a_s, sel_b_s;
    logic       stall_s;
    logic       bubble_s;

    function automatic logic is_writer(input stage_t st);
        return st.valid & st.reg_write & (st.rd != REG_ZERO);
    endfunction

    // The EX producer is newer than the MEM producer, so it is checked first.
    function automatic logic [1:0] fwd_select(input logic [REG_ADDR_W-1:0] src,
                                              input stage_t ex, input stage_t mem);
        logic [1:0] sel;
        if (is_writer(ex) && (ex.rd == src)) begin
            sel = 2'b01;
        end else if (is_writer(mem) && (mem.rd == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Select candidates for the ID instruction and the load-use stall.
    always_comb begin
        sel_a_s = fwd_select(bus.id_rs, ex_q, mem_q);
        if (bus.id_uses_rt) begin
            sel_b_s = fwd_select(bus.id_rt, ex_q, mem_q);
        end else begin
            sel_b_s = 2'b00;
        end
        stall_s = bus.id_valid & ~bus.flush & is_writer(ex_q) & ex_q.mem_read
                & ((ex_q.rd == bus.id_rs) | (bus.id_uses_rt & (ex_q.rd == bus.id_rt)));
    end

    // Next pipeline tracking state and registered selects.
    always_comb begin
        bubble_s    = bus.flush | stall_s | ~bus.id_valid;
        ex_d        = ex_q;
        mem_d       = mem_q;
        fwd_sel_a_d = fwd_sel_a_q;
        fwd_sel_b_d = fwd_sel_b_q;
        if (bus.freeze) begin
            ex_d        = ex_q;
            mem_d       = mem_q;
            fwd_sel_a_d = fwd_sel_a_q;
            fwd_sel_b_d = fwd_sel_b_q;
        end else begin
            mem_d = ex_q;
            if (bubble_s) begin
                ex_d        = BUBBLE;
                fwd_sel_a_d = 2'b00;
                fwd_sel_b_d = 2'b00;
            end else begin
                ex_d        = '{valid: 1'b1, rd: bus.id_rd, reg_write: bus.id_reg_write,
                                mem_read: bus.id_mem_read};
                fwd_sel_a_d = sel_a_s;
                fwd_sel_b_d = sel_b_s;
            end
        end
    end

`ifdef FWD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] fwd_count_q, fwd_count_d;

    // Saturating statistics counters, frozen together with the pipeline.
    always_comb begin
        if (~bus.freeze & stall_s & (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
        if (~bus.freeze & ((fwd_sel_a_d != 2'b00) | (fwd_sel_b_d != 2'b00)) & (fwd_count_q != CNT_MAX)) begin
            fwd_count_d = fwd_count_q + CNT_ONE;
        end else begin
            fwd_count_d = fwd_count_q;
        end
    end
`endif

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= BUBBLE;
            mem_q         <= BUBBLE;
            fwd_sel_a_q   <= 2'b00;
            fwd_sel_b_q   <= 2'b00;
`ifdef FWD_STATS_EN
            stall_count_q <= {CNT_W{1'b0}};
            fwd_count_q   <= {CNT_W{1'b0}};
`endif
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            fwd_sel_a_q   <= fwd_sel_a_d;
            fwd_sel_b_q   <= fwd_sel_b_d;
`ifdef FWD_STATS_EN
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
`endif
        end
    end

    assign bus.fwd_sel_a = fwd_sel_a_q;
    assign bus.fwd_sel_b = fwd_sel_b_q;
    assign bus.stall     = stall_s;
`ifdef FWD_STATS_EN
    assign bus.stall_count = stall_count_q;
    assign bus.fwd_count   = fwd_count_q;
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed hazard scenarios plus randomized traffic against an in-flight instruction model.
module tb_forwarding_unit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    forwarding_unit_if bus ();
    forwarding_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    instr_t     pipe [2];   // [0] = instruction in EX, [1] = instruction in MEM
    logic [1:0] exp_a, exp_b;
    bit         exp_stall;
    logic       stall_obs;
    int         n_cmp, n_err;
    int         exp_stall_cnt, exp_fwd_cnt;

    // Operand source: youngest in-flight producer of src wins; age 0 -> 01, age 1 -> 10.
    function automatic logic [1:0] model_sel(int src);
        for (int age = 0; age < 2; age++) begin
            if (pipe[age].valid && pipe[age].wr && pipe[age].rd != 0 && pipe[age].rd == src)
                return 2'(age + 1);
        end
        return 2'b00;
    endfunction

    function automatic bit model_stall(bit v, int rs, int rt, bit urt, bit fl);
        return v && !fl && pipe[0].valid && pipe[0].wr && pipe[0].ld && pipe[0].rd != 0
               && (pipe[0].rd == rs || (urt && pipe[0].rd == rt));
    endfunction

    task automatic model_reset();
        pipe[0] = '{1'b0, 0, 1'b0, 1'b0};
        pipe[1] = '{1'b0, 0, 1'b0, 1'b0};
        exp_a = 2'b00;
        exp_b = 2'b00;
        exp_stall_cnt = 0;
        exp_fwd_cnt = 0;
    endtask

    // One pipeline cycle: drive ID at negedge, sample stall, clock, advance the model.
    task automatic step(input bit v, input int rs, input int rt, input bit urt, input int rd,
                        input bit wr, input bit ld, input bit fl, input bit frz);
        logic [1:0] na, nb;
        @(negedge clk);
        bus.id_valid = v;      bus.id_rs = 5'(rs);  bus.id_rt = 5'(rt);
        bus.id_uses_rt = urt;  bus.id_rd = 5'(rd);  bus.id_reg_write = wr;
        bus.id_mem_read = ld;  bus.flush = fl;      bus.freeze = frz;
        #1;
        stall_obs = bus.stall;
        exp_stall = model_stall(v, rs, rt, urt, fl);
        @(posedge clk);
        if (!frz) begin
            if (fl || exp_stall || !v) begin
                na = 2'b00;
                nb = 2'b00;
            end else begin
                na = model_sel(rs);
                nb = urt ? model_sel(rt) : 2'b00;
            end
            if (exp_stall && exp_stall_cnt < 65535) exp_stall_cnt++;
            if ((na != 2'b00 || nb != 2'b00) && exp_fwd_cnt < 65535) exp_fwd_cnt++;
            pipe[1] = pipe[0];
            if (fl || exp_stall || !v) pipe[0] = '{1'b0, 0, 1'b0, 1'b0};
            else                       pipe[0] = '{1'b1, rd, wr, ld};
            exp_a = na;
            exp_b = nb;
        end
        #1;
    endtask

    task automatic bubbles();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.id_valid = 1'b1; bus.id_rs = 5'd3; bus.id_rt = 5'd3; bus.id_uses_rt = 1'b1;
        bus.id_rd = 5'd3; bus.id_reg_write = 1'b1; bus.id_mem_read = 1'b1;
        bus.flush = 1'b0; bus.freeze = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.fwd_sel_a !== 2'b00) begin n_err++; $display("FAIL reset_sel_a: got %b want 00", bus.fwd_sel_a); end
        n_cmp++; if (bus.fwd_sel_b !== 2'b00) begin n_err++; $display("FAIL reset_sel_b: got %b want 00", bus.fwd_sel_b); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
`ifdef FWD_STATS_EN
        n_cmp++; if (bus.stall_count !== 16'd0) begin n_err++; $display("FAIL reset_stall_count: got %0d want 0", bus.stall_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        bubbles();
    endtask

    task automatic test_ex_forward();
        bubbles();
        step(1, 1, 2, 1, 3, 1, 0, 0, 0);
        step(1, 3, 4, 1, 6, 1, 0, 0, 0);
        n_cmp++; if (bus.fwd_sel_a !== 2'b01) begin n_err++; $display("FAIL ex_fwd_sel_a: got %b want 01", bus.fwd_sel_a); end
        n_cmp++; if (bus.fwd_sel_b !== 2'b00) begin n_err++; $display("FAIL ex_fwd_sel_b: got %b want 00", bus.fwd_sel_b); end
        n_cmp++; if (stall_obs !== 1'b0) begin n_err++; $display("FAIL ex_fwd_stall: got %b want 0", stall_obs); end
    endtask

    task automatic test_mem_forward();
        bubbles();
        step(1, 1, 2, 1, 3, 1, 0, 0, 0);
        step(1, 1, 2, 1, 7, 1, 0, 0, 0);
        step(1, 8, 3, 1, 9, 1, 0, 0, 0);
        n_cmp++; if (bus.fwd_sel_b !== 2'b10) begin n_err++; $display("FAIL mem_fwd_sel_b: got %b want 10", bus.fwd_sel_b); end
        n_cmp++; if (bus.fwd_sel_a !== 2'b00) begin n_err++; $display("FAIL mem_fwd_sel_a: got %b want 00", bus.fwd_sel_a); end
    endtask

    task automatic test_priority();
        bubbles();
        step(1, 1, 2, 1, 5, 1, 0, 0, 0);
        step(1, 1, 2, 1, 5, 1, 0, 0, 0);
        step(1, 5, 9, 1, 10, 1, 0, 0, 0);
        n_cmp++; if (bus.fwd_sel_a !== 2'b01) begin n_err++; $display("FAIL prio_sel_a: got %b want 01", bus.fwd_sel_a); end
        n_cmp++; if (bus.fwd_sel_b !== 2'b00) begin n_err++; $display("FAIL prio_sel_b: got %b want 00", bus.fwd_sel_b); end
    endtask

    task automatic test_load_use();
        bubbles();
        step(1, 1, 0, 0, 4, 1, 1, 0, 0);
        step(1, 6, 4, 1, 8, 1, 0, 0, 0);
        n_cmp++; if (stall_obs !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", stall_obs); end
        n_cmp++; if (bus.fwd_sel_b !== 2'b00) begin n_err++; $display("FAIL lu_bubble_sel_b: got %b want 00", bus.fwd_sel_b); end
        step(1, 6, 4, 1, 8, 1, 0, 0, 0);
        n_cmp++; if (stall_obs !== 1'b0) begin n_err++; $display("FAIL lu_stall_release: got %b want 0", stall_obs); end
        n_cmp++; if (bus.fwd_sel_b !== 2'b10) begin n_err++; $display("FAIL lu_sel_b: got %b want 10", bus.fwd_sel_b); end
        n_cmp++; if (bus.fwd_sel_a !== 2'b00) begin n_err++; $display("FAIL lu_sel_a: got %b want 00", bus.fwd_sel_a); end
    endtask

    task automatic test_ignored_sources();
        bubbles();
        step(1, 1, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 5, 1, 0, 0, 0);
        n_cmp++; if (stall_obs !== 1'b0) begin n_err++; $display("FAIL zero_stall: got %b want 0", stall_obs); end
        n_cmp++; if (bus.fwd_sel_a !== 2'b00 || bus.fwd_sel_b !== 2'b00) begin n_err++; $display("FAIL zero_sels: got %b/%b want 00/00", bus.fwd_sel_a, bus.fwd_sel_b); end
        step(1, 1, 2, 1, 7, 0, 0, 0, 0);
        step(1, 7, 7, 1, 11, 1, 0, 0, 0);
        n_cmp++; if (bus.fwd_sel_a !== 2'b00 || bus.fwd_sel_b !== 2'b00) begin n_err++; $display("FAIL nowrite_sels: got %b/%b want 00/00", bus.fwd_sel_a, bus.fwd_sel_b); end
        step(1, 1, 2, 1, 9, 1, 1, 0, 0);
        step(1, 1, 9, 0, 10, 1, 0, 0, 0);
        n_cmp++; if (stall_obs !== 1'b0) begin n_err++; $display("FAIL nouse_rt_stall: got %b want 0", stall_obs); end
        n_cmp++; if (bus.fwd_sel_b !== 2'b00) begin n_err++; $display("FAIL nouse_rt_sel_b: got %b want 00", bus.fwd_sel_b); end
    endtask

    task automatic test_freeze();
        bubbles();
        step(1, 1, 2, 1, 3, 1, 0, 0, 0);
        step(1, 3, 0, 0, 4, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 4, 5, 1, 9, 1, 0, 0, 1);
            n_cmp++; if (stall_obs !== 1'b1) begin n_err++; $display("FAIL frz_stall[%0d]: got %b want 1", i, stall_obs); end
            n_cmp++; if (bus.fwd_sel_a !== 2'b01) begin n_err++; $display("FAIL frz_sel_a[%0d]: got %b want 01", i, bus.fwd_sel_a); end
        end
        step(1, 4, 5, 1, 9, 1, 0, 0, 0);
        n_cmp++; if (stall_obs !== 1'b1 || bus.fwd_sel_a !== 2'b00) begin n_err++; $display("FAIL frz_release: got stall %b sel_a %b want 1/00", stall_obs, bus.fwd_sel_a); end
        step(1, 4, 5, 1, 9, 1, 0, 0, 0);
        n_cmp++; if (stall_obs !== 1'b0 || bus.fwd_sel_a !== 2'b10) begin n_err++; $display("FAIL frz_consumer: got stall %b sel_a %b want 0/10", stall_obs, bus.fwd_sel_a); end
    endtask

    task automatic test_flush();
        bubbles();
        step(1, 1, 2, 1, 3, 1, 0, 0, 0);
        step(1, 3, 3, 1, 6, 1, 0, 1, 0);
        n_cmp++; if (bus.fwd_sel_a !== 2'b00 || bus.fwd_sel_b !== 2'b00) begin n_err++; $display("FAIL flush_sels: got %b/%b want 00/00", bus.fwd_sel_a, bus.fwd_sel_b); end
        step(1, 0, 0, 0, 4, 1, 1, 0, 0);
        step(1, 4, 0, 0, 6, 1, 0, 1, 0);
        n_cmp++; if (stall_obs !== 1'b0) begin n_err++; $display("FAIL flush_over_stall: got %b want 0", stall_obs); end
        n_cmp++; if (bus.fwd_sel_a !== 2'b00) begin n_err++; $display("FAIL flush_over_stall_sel: got %b want 00", bus.fwd_sel_a); end
        step(1, 4, 0, 0, 6, 1, 0, 0, 0);
        n_cmp++; if (stall_obs !== 1'b0 || bus.fwd_sel_a !== 2'b10) begin n_err++; $display("FAIL flush_after: got stall %b sel_a %b want 0/10", stall_obs, bus.fwd_sel_a); end
    endtask

    task automatic test_async_reset();
        bubbles();
        step(1, 1, 2, 1, 3, 1, 0, 0, 0);
        step(1, 3, 0, 0, 4, 1, 1, 0, 0);
        n_cmp++; if (bus.fwd_sel_a !== 2'b01) begin n_err++; $display("FAIL arst_pre_sel_a: got %b want 01", bus.fwd_sel_a); end
        @(negedge clk);
        bus.id_valid = 1'b1; bus.id_rs = 5'd4; bus.id_uses_rt = 1'b0; bus.flush = 1'b0; bus.freeze = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL arst_pre_stall: got %b want 1", bus.stall); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL arst_stall: got %b want 0", bus.stall); end
        n_cmp++; if (bus.fwd_sel_a !== 2'b00 || bus.fwd_sel_b !== 2'b00) begin n_err++; $display("FAIL arst_sels: got %b/%b want 00/00", bus.fwd_sel_a, bus.fwd_sel_b); end
        model_reset();
        @(negedge clk);
        bus.id_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) < 85, $urandom_range(7), $urandom_range(7), $urandom_range(1),
                 $urandom_range(7), $urandom_range(99) < 75, $urandom_range(99) < 30,
                 $urandom_range(99) < 10, $urandom_range(99) < 10);
            n_cmp++; if (stall_obs !== exp_stall) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall_obs, exp_stall); end
            n_cmp++; if (bus.fwd_sel_a !== exp_a) begin n_err++; $display("FAIL rnd_sel_a[%0d]: got %b want %b", i, bus.fwd_sel_a, exp_a); end
            n_cmp++; if (bus.fwd_sel_b !== exp_b) begin n_err++; $display("FAIL rnd_sel_b[%0d]: got %b want %b", i, bus.fwd_sel_b, exp_b); end
`ifdef FWD_STATS_EN
            n_cmp++; if (int'(bus.stall_count) != exp_stall_cnt) begin n_err++; $display("FAIL rnd_stall_count[%0d]: got %0d want %0d", i, bus.stall_count, exp_stall_cnt); end
            n_cmp++; if (int'(bus.fwd_count) != exp_fwd_cnt) begin n_err++; $display("FAIL rnd_fwd_count[%0d]: got %0d want %0d", i, bus.fwd_count, exp_fwd_cnt); end
`endif
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_priority();
        test_load_use();
        test_ignored_sources();
        test_freeze();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
